// File: rtl/mpa_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package mpa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mpa_state_t;

  // Word counter width: at least one bit, even when WORDS == 1.
  function automatic int unsigned cnt_width(input int unsigned words);
    int unsigned w;
    w = $clog2(words);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mpa_seq_ksa.sv
// Kogge-Stone adder core: BITS-wide, carry-in folded into bit 0 generate.
module KSA #(
  parameter int unsigned BITS   = 64,
  parameter int unsigned LEVELS = 6
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS:0]   s
);

  logic [BITS-1:0] w_p0;
  logic [BITS-1:0] w_g [0:LEVELS];
  logic [BITS-1:0] w_p [0:LEVELS];

  always_comb begin
    w_p0    = a ^ b;
    w_g[0]  = a & b;
    w_g[0][0] = (a[0] & b[0]) | (w_p0[0] & cin);
    w_p[0]  = w_p0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      w_g[l+1] = w_g[l];
      w_p[l+1] = w_p[l];
      for (int unsigned i = 0; i < BITS; i++) begin
        if (i >= (32'd1 << l)) begin
          w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i - (32'd1 << l)]);
          w_p[l+1][i] = w_p[l][i] & w_p[l][i - (32'd1 << l)];
        end
      end
    end
    s = {w_g[LEVELS][BITS-1], w_p0 ^ {w_g[LEVELS][BITS-2:0], cin}};
  end

endmodule

// File: rtl/mpa_seq.sv
// Multi-precision add/subtract sequencer: one word per cycle through a shared
// Kogge-Stone core, carry chained between words through r_carry.
module mpa_seq
  import mpa_pkg::*;
#(
  parameter int unsigned WORD_BITS = 64,
  parameter int unsigned LEVELS    = 6,
  parameter int unsigned WORDS     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORDS*WORD_BITS-1:0]   a,
  input  logic [WORDS*WORD_BITS-1:0]   b,
  input  logic                         cin,
  input  logic                         sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORDS*WORD_BITS:0]     s
);

  localparam int unsigned W  = WORDS * WORD_BITS;
  localparam int unsigned CW = cnt_width(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  mpa_state_t r_state, w_state_nxt;

  logic [W-1:0]         r_a, r_b;
  logic                 r_sub;
  logic                 r_carry;
  logic [CW-1:0]        r_cnt;
  logic [W:0]           r_s;

  logic [WORD_BITS-1:0] w_a_word, w_b_word;
  logic [WORD_BITS:0]   w_sum;
  logic                 w_accept, w_last;

  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_last    = (r_cnt == LAST);
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign s         = r_s;

  assign w_a_word = r_a[r_cnt*WORD_BITS +: WORD_BITS];
  assign w_b_word = r_b[r_cnt*WORD_BITS +: WORD_BITS] ^ {WORD_BITS{r_sub}};

  KSA #(
    .BITS   (WORD_BITS),
    .LEVELS (LEVELS)
  ) u_ksa (
    .a   (w_a_word),
    .b   (w_b_word),
    .cin (r_carry),
    .s   (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Subtract is A + ~B + ~cin, so the initial carry is cin ^ sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= sub;
      r_carry <= cin ^ sub;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_s[r_cnt*WORD_BITS +: WORD_BITS] <= w_sum[WORD_BITS-1:0];
      r_carry <= w_sum[WORD_BITS];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_s[W] <= w_sum[WORD_BITS];
    end
  end

endmodule
